// File: rtl/pool_engine_multi_core_if.sv
// Bus bundle between the layer sequencer / feature-map BRAMs (master) and the
// multi-core pooling engine (slave).
interface pool_engine_multi_core_if #(
  parameter int unsigned CORES      = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned IN_ADDR_W  = 13,
  parameter int unsigned OUT_ADDR_W = 11,
  parameter int unsigned SIZE_W     = 8
);
  logic                        start;
  logic                        mode;
  logic [SIZE_W-1:0]           map_size;
  logic [IN_ADDR_W-1:0]        in_base;
  logic [OUT_ADDR_W-1:0]       out_base;
  logic [CORES*IN_ADDR_W-1:0]  rd_addr;
  logic [CORES*DATA_W-1:0]     rd_data;
  logic [CORES-1:0]            wr_en;
  logic [CORES*OUT_ADDR_W-1:0] wr_addr;
  logic [CORES*DATA_W-1:0]     wr_data;
  logic                        busy;
  logic                        done;
  logic                        err;

  modport master (
    output start, mode, map_size, in_base, out_base, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, mode, map_size, in_base, out_base, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/pool_engine_multi_core.sv
// Multi-core 2x2/stride-2 average/max pooling engine, one shared address stream.
// Optional: define POOL_ROUND_EN to round average results half toward +inf.
module pool_engine_multi_core #(
  parameter int unsigned CORES      = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned IN_ADDR_W  = 13,
  parameter int unsigned OUT_ADDR_W = 11,
  parameter int unsigned SIZE_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  pool_engine_multi_core_if.slave bus
);

  localparam int unsigned ACC_W = DATA_W + 2;
`ifdef POOL_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(2);
`else
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(0);
`endif

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              phase_q, phase_d;
  logic                    mode_q, mode_d;
  logic [SIZE_W-1:0]       size_q, size_d;
  logic [SIZE_W-1:0]       ox_q, ox_d;
  logic [SIZE_W-1:0]       oy_q, oy_d;
  logic [IN_ADDR_W-1:0]    win_addr_q, win_addr_d;
  logic [IN_ADDR_W-1:0]    row_addr_q, row_addr_d;
  logic [OUT_ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [IN_ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [OUT_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [CORES*DATA_W-1:0] wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic signed [ACC_W-1:0] acc_q [CORES];
  logic signed [ACC_W-1:0] acc_d [CORES];

  logic signed [ACC_W-1:0] samp_c [CORES];
  logic signed [ACC_W-1:0] sum_c  [CORES];
  logic signed [ACC_W-1:0] max_c  [CORES];
  logic [DATA_W-1:0]       avg_c  [CORES];
  logic [IN_ADDR_W-1:0]    stride_c;
  logic [SIZE_W-1:0]       half_c;
  logic                    last_col_c;
  logic                    last_win_c;

  assign stride_c   = IN_ADDR_W'(size_q);
  assign half_c     = size_q >> 1;
  assign last_col_c = (ox_q == half_c - SIZE_W'(1));
  assign last_win_c = last_col_c && (oy_q == half_c - SIZE_W'(1));

  // Per-lane datapath: sign-extended sample, running sum, running max, final average.
  always_comb begin
    for (int i = 0; i < CORES; i++) begin
      samp_c[i] = {{2{bus.rd_data[i*DATA_W + DATA_W - 1]}}, bus.rd_data[i*DATA_W +: DATA_W]};
      sum_c[i]  = acc_q[i] + samp_c[i];
      max_c[i]  = (samp_c[i] > acc_q[i]) ? samp_c[i] : acc_q[i];
      avg_c[i]  = DATA_W'((sum_c[i] + RND) >>> 2);
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    size_d     = size_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    win_addr_d = win_addr_q;
    row_addr_d = row_addr_q;
    out_addr_d = out_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    acc_d      = acc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d = bus.mode;
          size_d = bus.map_size;
          err_d  = 1'b0;
          if (bus.map_size[0] || (bus.map_size == '0)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            state_d    = RUN;
            busy_d     = 1'b1;
            phase_d    = 3'd0;
            ox_d       = '0;
            oy_d       = '0;
            win_addr_d = bus.in_base;
            row_addr_d = bus.in_base;
            out_addr_d = bus.out_base;
            rd_addr_d  = bus.in_base;
          end
        end
      end

      RUN: begin
        // Read data lags the address by one cycle, so phase k+1 consumes sample k.
        case (phase_q)
          3'd0: begin
            rd_addr_d = win_addr_q + IN_ADDR_W'(1);
            phase_d   = 3'd1;
          end
          3'd1: begin
            for (int i = 0; i < CORES; i++) acc_d[i] = samp_c[i];
            rd_addr_d = win_addr_q + stride_c;
            phase_d   = 3'd2;
          end
          3'd2: begin
            for (int i = 0; i < CORES; i++) acc_d[i] = mode_q ? max_c[i] : sum_c[i];
            rd_addr_d = win_addr_q + stride_c + IN_ADDR_W'(1);
            phase_d   = 3'd3;
          end
          3'd3: begin
            for (int i = 0; i < CORES; i++) acc_d[i] = mode_q ? max_c[i] : sum_c[i];
            phase_d = 3'd4;
          end
          default: begin
            wr_en_d   = 1'b1;
            wr_addr_d = out_addr_q;
            for (int i = 0; i < CORES; i++) begin
              wr_data_d[i*DATA_W +: DATA_W] = mode_q ? max_c[i][DATA_W-1:0] : avg_c[i];
            end
            out_addr_d = out_addr_q + OUT_ADDR_W'(1);
            phase_d    = 3'd0;
            if (last_win_c) begin
              state_d = FLUSH;
            end else if (last_col_c) begin
              ox_d       = '0;
              oy_d       = oy_q + SIZE_W'(1);
              row_addr_d = row_addr_q + (stride_c << 1);
              win_addr_d = row_addr_q + (stride_c << 1);
              rd_addr_d  = row_addr_q + (stride_c << 1);
            end else begin
              ox_d       = ox_q + SIZE_W'(1);
              win_addr_d = win_addr_q + IN_ADDR_W'(2);
              rd_addr_d  = win_addr_q + IN_ADDR_W'(2);
            end
          end
        endcase
      end

      FLUSH: begin
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      mode_q     <= 1'b0;
      size_q     <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      win_addr_q <= '0;
      row_addr_q <= '0;
      out_addr_q <= '0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < CORES; i++) acc_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      size_q     <= size_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      win_addr_q <= win_addr_d;
      row_addr_q <= row_addr_d;
      out_addr_q <= out_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      for (int i = 0; i < CORES; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Control and addresses are common to every lane.
  assign bus.rd_addr = {CORES{rd_addr_q}};
  assign bus.wr_en   = {CORES{wr_en_q}};
  assign bus.wr_addr = {CORES{wr_addr_q}};
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_pool_engine_multi_core.sv
// Directed bench for pool_engine_multi_core: BRAM model per lane, cycle-accurate
// timing, average/max results, invalid sizes, address wrap and mid-run reset.
module tb_pool_engine_multi_core;

  localparam int unsigned CORES      = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned IN_ADDR_W  = 13;
  localparam int unsigned OUT_ADDR_W = 11;
  localparam int unsigned SIZE_W     = 8;
  localparam int unsigned MEM_D      = 1 << IN_ADDR_W;

`ifdef POOL_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool_engine_multi_core_if #(
    .CORES(CORES), .DATA_W(DATA_W), .IN_ADDR_W(IN_ADDR_W),
    .OUT_ADDR_W(OUT_ADDR_W), .SIZE_W(SIZE_W)
  ) bus ();

  pool_engine_multi_core #(
    .CORES(CORES), .DATA_W(DATA_W), .IN_ADDR_W(IN_ADDR_W),
    .OUT_ADDR_W(OUT_ADDR_W), .SIZE_W(SIZE_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous-read BRAM per lane.
  logic [DATA_W-1:0] mem  [CORES][MEM_D];
  logic [DATA_W-1:0] rd_q [CORES];

  always @(posedge clk) begin
    for (int i = 0; i < CORES; i++) rd_q[i] <= mem[i][bus.rd_addr[i*IN_ADDR_W +: IN_ADDR_W]];
  end

  always_comb begin
    for (int i = 0; i < CORES; i++) bus.rd_data[i*DATA_W +: DATA_W] = rd_q[i];
  end

  int n_tests = 0;
  int n_fail  = 0;

  int wr_cnt;
  int wr_adr [16];
  int wr_dat [16][CORES];
  int rd_log [64];
  int done_cyc;
  int busy_cnt;
  int err_c1;
  int lanes_same;

  int avg0_f [4] = '{2, 4, 10, 12};
  int avg0_r [4] = '{3, 5, 11, 13};
  int avg1_f [4] = '{-4, -6, -12, -14};
  int avg1_r [4] = '{-3, -5, -11, -13};
  int max0   [4] = '{5, 7, 13, 15};
  int max1   [4] = '{-1, -3, -9, -11};

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic record_write();
    if (bus.wr_en != '0) begin
      if (bus.wr_en != {CORES{1'b1}}) lanes_same = 0;
      if (wr_cnt < 16) begin
        wr_adr[wr_cnt] = int'(bus.wr_addr[OUT_ADDR_W-1:0]);
        for (int i = 0; i < CORES; i++) begin
          wr_dat[wr_cnt][i] = int'($signed(bus.wr_data[i*DATA_W +: DATA_W]));
        end
      end
      wr_cnt++;
    end
  endtask

  // Issue one start and observe the run cycle by cycle (cycle 1 = first after the start edge).
  task automatic run_pool(input int s, input bit m, input int ib, input int ob,
                          input bit spam, input int rst_at);
    int n;
    wr_cnt = 0; done_cyc = 0; busy_cnt = 0; err_c1 = -1; lanes_same = 1;
    for (int i = 0; i < 64; i++) rd_log[i] = -1;
    @(negedge clk);
    bus.map_size = SIZE_W'(s);
    bus.mode     = m;
    bus.in_base  = IN_ADDR_W'(ib);
    bus.out_base = OUT_ADDR_W'(ob);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n <= 200) begin
      if (n == 1) err_c1 = int'(bus.err);
      if (n <= 64) rd_log[n-1] = int'(bus.rd_addr[IN_ADDR_W-1:0]);
      if (bus.rd_addr != {CORES{bus.rd_addr[IN_ADDR_W-1:0]}}) lanes_same = 0;
      if (bus.busy) busy_cnt++;
      record_write();
      if (bus.done) begin
        done_cyc = n;
        break;
      end
      if (rst_at != 0 && n == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_mid_busy",  int'(bus.busy), 0);
        check("rst_mid_wr_en", int'(bus.wr_en), 0);
        check("rst_mid_done",  int'(bus.done), 0);
        check("rst_mid_rd",    int'(bus.rd_addr != '0), 0);
        check("rst_mid_wdata", int'(bus.wr_data != '0), 0);
        repeat (3) begin
          @(negedge clk);
          record_write();
        end
        reset = 1'b0;
        break;
      end
      bus.start = spam && (n == 3 || n == 12);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.map_size = '0;
    bus.in_base  = '0;
    bus.out_base = '0;
    for (int l = 0; l < CORES; l++)
      for (int a = 0; a < MEM_D; a++) mem[l][a] = '0;
    for (int i = 0; i < 16; i++) begin
      mem[0][i] = DATA_W'(i);
      mem[1][i] = DATA_W'(-(i + 1));
      mem[2][i] = DATA_W'(32767);
      mem[3][i] = DATA_W'(-32768);
    end
    mem[0][8190] = DATA_W'(20);
    mem[0][8191] = DATA_W'(40);
    mem[0][100] = DATA_W'(7);
    mem[0][101] = DATA_W'(-7);
    mem[0][102] = DATA_W'(3);
    mem[0][103] = DATA_W'(1);
    mem[1][100] = DATA_W'(-1);
    mem[1][101] = DATA_W'(-2);
    mem[1][102] = DATA_W'(-3);
    mem[1][103] = DATA_W'(-4);

    repeat (3) @(negedge clk);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_done",  int'(bus.done), 0);
    check("rst_err",   int'(bus.err), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_rd",    int'(bus.rd_addr != '0), 0);
    reset = 1'b0;

    // S=4 average, with stray start pulses mid-run
    run_pool(4, 1'b0, 0, 0, 1'b1, 0);
    check("avg_done_cyc", done_cyc, 22);
    check("avg_busy_cnt", busy_cnt, 21);
    check("avg_wr_cnt", wr_cnt, 4);
    check("avg_lanes_same", lanes_same, 1);
    check("avg_rd0", rd_log[0], 0);
    check("avg_rd1", rd_log[1], 1);
    check("avg_rd2", rd_log[2], 4);
    check("avg_rd3", rd_log[3], 5);
    check("avg_rd_w1", rd_log[5], 2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("avg_addr%0d", k), wr_adr[k], k);
      check($sformatf("avg_l0_%0d", k), wr_dat[k][0], RND ? avg0_r[k] : avg0_f[k]);
      check($sformatf("avg_l1_%0d", k), wr_dat[k][1], RND ? avg1_r[k] : avg1_f[k]);
      check($sformatf("avg_l2_%0d", k), wr_dat[k][2], 32767);
      check($sformatf("avg_l3_%0d", k), wr_dat[k][3], -32768);
    end

    // S=4 max
    run_pool(4, 1'b1, 0, 0, 1'b0, 0);
    check("max_done_cyc", done_cyc, 22);
    check("max_wr_cnt", wr_cnt, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("max_l0_%0d", k), wr_dat[k][0], max0[k]);
      check($sformatf("max_l1_%0d", k), wr_dat[k][1], max1[k]);
      check($sformatf("max_l3_%0d", k), wr_dat[k][3], -32768);
    end

    // Invalid sizes
    run_pool(5, 1'b0, 0, 0, 1'b0, 0);
    check("odd_done_cyc", done_cyc, 1);
    check("odd_err", err_c1, 1);
    check("odd_wr_cnt", wr_cnt, 0);
    @(negedge clk);
    check("odd_err_sticky", int'(bus.err), 1);
    check("odd_busy", int'(bus.busy), 0);
    run_pool(0, 1'b0, 0, 0, 1'b0, 0);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_err", err_c1, 1);
    check("zero_wr_cnt", wr_cnt, 0);

    // S=2 clears err, single window
    run_pool(2, 1'b0, 100, 5, 1'b0, 0);
    check("s2_err_clr", err_c1, 0);
    check("s2_done_cyc", done_cyc, 7);
    check("s2_wr_cnt", wr_cnt, 1);
    check("s2_addr", wr_adr[0], 5);
    check("s2_l0", wr_dat[0][0], 1);
    check("s2_l1", wr_dat[0][1], RND ? -2 : -3);

    // Address wrap on both sides
    run_pool(4, 1'b0, 8190, 2047, 1'b0, 0);
    check("wrap_rd0", rd_log[0], 8190);
    check("wrap_rd1", rd_log[1], 8191);
    check("wrap_rd2", rd_log[2], 2);
    check("wrap_rd3", rd_log[3], 3);
    check("wrap_rd_w1", rd_log[5], 0);
    check("wrap_lanes_same", lanes_same, 1);
    check("wrap_wr_cnt", wr_cnt, 4);
    check("wrap_addr0", wr_adr[0], 2047);
    check("wrap_addr1", wr_adr[1], 0);
    check("wrap_l0_0", wr_dat[0][0], 16);
    check("wrap_l0_1", wr_dat[1][0], RND ? 3 : 2);

    // Reset during the second window
    run_pool(4, 1'b0, 0, 0, 1'b0, 8);
    check("rst_run_wr_cnt", wr_cnt, 1);
    check("rst_run_done", done_cyc, 0);

    // Fresh run after reset
    run_pool(4, 1'b1, 0, 0, 1'b0, 0);
    check("post_rst_done_cyc", done_cyc, 22);
    check("post_rst_wr_cnt", wr_cnt, 4);
    check("post_rst_l0_0", wr_dat[0][0], 5);
    check("post_rst_l0_3", wr_dat[3][0], 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
